// File: rtl/rng_pkg.sv
// ---------------------------------------------------------------------------
// rng_pkg -- shared definitions for the random-bit harvester.
//   * FSM state encoding (IDLE, RELEASE, FREEZE, CAPTURE, DEBIAS)
//   * SYNC_STAGES / FREEZE_CYCLES timing constants
//   * cnt_w(): width of a counter that must hold the values 0..n-1
// ---------------------------------------------------------------------------
package rng_pkg;

    localparam int SYNC_STAGES   = 2;
    // The sources stay frozen long enough for the frozen value to clear the
    // synchroniser before it is snapshotted.
    localparam int FREEZE_CYCLES = SYNC_STAGES + 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t RELEASE = 3'd1;
    localparam state_t FREEZE  = 3'd2;
    localparam state_t CAPTURE = 3'd3;
    localparam state_t DEBIAS  = 3'd4;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rng_sync.sv
// ---------------------------------------------------------------------------
// rng_sync -- WIDTH-bit two-flop synchroniser for the asynchronous latch
// outputs. Both stages clear to 0 on reset.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   din  [WIDTH-1:0] asynchronous raw bits
//   dout [WIDTH-1:0] bits synchronised to clk
// ---------------------------------------------------------------------------
module rng_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            // NOTE: non-blocking assignments make both stages sample on the
            // same edge; blocking here would collapse the chain to one flop.
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/rng_harvester.sv
// ---------------------------------------------------------------------------
// rng_harvester -- drives the shared freeze line of the NAND-latch sources,
// snapshots their synchronised outputs once per pass, Von Neumann debiases
// the snapshot pair by pair and packs accepted bits LSB-first into OUT_W-bit
// words delivered on a valid/ready handshake.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             start/continue passes (sampled in IDLE and at pass end)
//   raw_in         raw latch outputs, asynchronous to clk
//   gen_hold       freeze line to the sources (0 = free-running, 1 = frozen)
//   rnd_data       harvested word, stable while rnd_valid waits for ready
//   rnd_valid      rnd_data holds an untransferred word
//   rnd_ready      consumer accepts the word
//   health_fail    sticky repetition-test failure
// Build option: define RNG_HEALTH_EN to build the repetition health test;
// without it health_fail is tied low.
// ---------------------------------------------------------------------------
module rng_harvester
    import rng_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_W     = 8,
    parameter int SETTLE    = 4,
    parameter int REP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic             gen_hold,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             health_fail
);

    localparam int NPAIRS    = WIDTH / 2;
    localparam int PW        = cnt_w(NPAIRS);
    localparam int BW        = cnt_w(OUT_W);
    localparam int PHASE_MAX = (SETTLE > FREEZE_CYCLES) ? SETTLE : FREEZE_CYCLES;
    localparam int CW        = cnt_w(PHASE_MAX);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_CYCLES - 1);
    localparam logic [PW-1:0] PAIR_LAST   = PW'(NPAIRS - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(OUT_W - 1);

    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] snap;
    state_t           state, state_next;
    logic [CW-1:0]    phase;
    logic [PW-1:0]    pair_idx;
    logic [BW-1:0]    bit_cnt;
    logic [OUT_W-2:0] acc;          // top bit of a word is never stored: it completes the word
    logic             health_fail_q;

    logic [1:0]       pair;
    logic             bit_a, emit, xfer, word_done, stall, load;
    logic [OUT_W-1:0] word;

    rng_sync #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (raw_in),
        .dout (sync_bits)
    );

    always_comb begin
        // NOTE: every combinational output is defaulted up front so no path
        // through the case statement leaves one unassigned (no latches).
        state_next = state;
        pair       = snap[{pair_idx, 1'b0} +: 2];
        bit_a      = pair[0];
        emit       = pair[0] ^ pair[1];     // 01 -> 0, 10 -> 1, 00/11 discarded
        word       = {bit_a, acc};
        xfer       = rnd_valid & rnd_ready;
        word_done  = (state == DEBIAS) && emit && (bit_cnt == BIT_LAST);
        // A finished word with nowhere to go freezes the debias walk; once
        // the health test has tripped, finished words are dropped instead.
        stall      = word_done && rnd_valid && !xfer && !health_fail_q;
        load       = word_done && !rnd_valid_block();

        case (state)
            IDLE:    if (en) state_next = RELEASE;
            RELEASE: if (phase == SETTLE_LAST) state_next = FREEZE;
            FREEZE:  if (phase == FREEZE_LAST) state_next = CAPTURE;
            CAPTURE: state_next = DEBIAS;
            DEBIAS:  if (!stall && pair_idx == PAIR_LAST)
                         state_next = en ? RELEASE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    function automatic logic rnd_valid_block();
        return stall || health_fail_q;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gen_hold  <= 1'b1;
            phase     <= '0;
            pair_idx  <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            // NOTE: the snapshot is a plain register bank, so it is reset with
            // everything else; a RAM-style array would not be.
            snap      <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            // Registered so the line to the sources never glitches on decode.
            gen_hold <= (state_next != RELEASE);

            if (state_next != state)
                phase <= '0;
            else if (state == RELEASE || state == FREEZE)
                phase <= phase + CW'(1);

            if (state == CAPTURE) begin
                snap     <= sync_bits;
                pair_idx <= '0;
            end

            if (state == DEBIAS && !stall) begin
                pair_idx <= pair_idx + PW'(1);
                if (emit) begin
                    if (word_done) begin
                        bit_cnt <= '0;
                    end else begin
                        acc[bit_cnt] <= bit_a;
                        bit_cnt      <= bit_cnt + BW'(1);
                    end
                end
            end

            if (load) begin
                rnd_data  <= word;
                rnd_valid <= 1'b1;
            end else if (xfer) begin
                rnd_valid <= 1'b0;
            end
        end
    end

`ifdef RNG_HEALTH_EN
    localparam int RW = cnt_w(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    logic [WIDTH-1:0] prev_snap;
    logic             have_prev;
    logic [RW-1:0]    rep_cnt, rep_next;

    always_comb begin
        rep_next = rep_cnt;
        if (!have_prev || sync_bits != prev_snap)
            rep_next = RW'(1);
        else if (rep_cnt != REP_MAX)
            rep_next = rep_cnt + RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_snap     <= '0;
            have_prev     <= 1'b0;
            rep_cnt       <= '0;
            health_fail_q <= 1'b0;
        end else if (state == CAPTURE) begin
            prev_snap <= sync_bits;
            have_prev <= 1'b1;
            rep_cnt   <= rep_next;
            if (rep_next == REP_MAX)
                health_fail_q <= 1'b1;
        end
    end
`else
    assign health_fail_q = 1'b0;
`endif

    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_rng_harvester.sv
// ---------------------------------------------------------------------------
// tb_rng_harvester -- directed bench for rng_harvester (default parameters:
// WIDTH=16, OUT_W=8, SETTLE=4, REP_LIMIT=4). One pass with en held high is
// 16 cycles: RELEASE 4, FREEZE 3, CAPTURE 1, DEBIAS 8.
// ---------------------------------------------------------------------------
module tb_rng_harvester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] raw_in = '0;
    logic        gen_hold;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        rnd_ready = 1'b0;
    logic        health_fail;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rng_harvester dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .raw_in     (raw_in),
        .gen_hold   (gen_hold),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .health_fail(health_fail)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; rnd_ready = 1'b0; raw_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int n, output bit found);
        found = 1'b0;
        for (int i = 0; i < n && !found; i++) begin
            @(negedge clk);
            if (rnd_valid) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        raw_in = 16'hAAAA; rnd_ready = 1'b1; en = 1'b1;
        repeat (20) @(negedge clk);      // first word loaded, pass 2 releasing
        rst_n = 1'b0;
        #1;
        total++; if (gen_hold !== 1'b1) begin bad++; $display("FAIL reset_gen_hold: got %b want 1", gen_hold); end
        total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
        total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rnd_data); end
        total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health: got %b want 0", health_fail); end
    endtask

    task automatic test_hold_window();
        int lows;
        bit found;
        do_reset();
        raw_in = 16'hAAAA; rnd_ready = 1'b1; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!gen_hold) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL hold_release_seen: got none want gen_hold low"); end
        lows = 0;
        while (!gen_hold && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        total++; if (lows !== 4) begin bad++; $display("FAIL hold_low_cycles: got %0d want 4", lows); end
        wait_valid(30, found);
        total++; if (!found) begin bad++; $display("FAIL aaaa_valid: got timeout want valid"); end
        total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL aaaa_data: got %h want 00", rnd_data); end
        @(negedge clk);
        total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL aaaa_pulse: got %b want 0", rnd_valid); end
    endtask

    task automatic test_pattern(input logic [15:0] pat, input logic [7:0] exp_word);
        bit found;
        do_reset();
        raw_in = pat; rnd_ready = 1'b1; en = 1'b1;
        wait_valid(30, found);
        total++; if (!found) begin bad++; $display("FAIL pattern_valid %h: got timeout want valid", pat); end
        total++; if (rnd_data !== exp_word) begin bad++; $display("FAIL pattern_data %h: got %h want %h", pat, rnd_data, exp_word); end
    endtask

    task automatic test_all_discard();
        int valids, releases;
        logic prev;
        do_reset();
        raw_in = 16'h0000; rnd_ready = 1'b1; en = 1'b1;
        valids = 0; releases = 0; prev = gen_hold;
        repeat (40) begin
            @(negedge clk);
            if (rnd_valid) valids++;
            if (prev && !gen_hold) releases++;
            prev = gen_hold;
        end
        total++; if (valids !== 0) begin bad++; $display("FAIL discard_valid: got %0d want 0", valids); end
        total++; if (releases !== 3) begin bad++; $display("FAIL discard_releases: got %0d want 3", releases); end
    endtask

    task automatic test_back_to_back();
        bit found;
        int moved;
        do_reset();
        raw_in = 16'h5555; rnd_ready = 1'b0; en = 1'b1;
        wait_valid(30, found);
        total++; if (!found) begin bad++; $display("FAIL stall_first_valid: got timeout want valid"); end
        total++; if (rnd_data !== 8'hFF) begin bad++; $display("FAIL stall_first_data: got %h want ff", rnd_data); end
        moved = 0;
        repeat (30) begin
            @(negedge clk);
            if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) moved++;
        end
        total++; if (moved !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", moved); end
        total++; if (gen_hold !== 1'b1) begin bad++; $display("FAIL stall_gen_hold: got %b want 1", gen_hold); end
        rnd_ready = 1'b1;
        @(negedge clk);
        rnd_ready = 1'b0;
        total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL reload_valid: got %b want 1", rnd_valid); end
        total++; if (rnd_data !== 8'hFF) begin bad++; $display("FAIL reload_data: got %h want ff", rnd_data); end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (!gen_hold) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL resume_release: got none want gen_hold low"); end
        repeat (30) @(negedge clk);      // stalls again with a word pending
        rst_n = 1'b0;
        #1;
        total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL stall_reset_valid: got %b want 0", rnd_valid); end
        total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL stall_reset_data: got %h want 00", rnd_data); end
        total++; if (gen_hold !== 1'b1) begin bad++; $display("FAIL stall_reset_gen_hold: got %b want 1", gen_hold); end
    endtask

    task automatic test_health();
        int words;
        do_reset();
        raw_in = 16'h55AA; rnd_ready = 1'b1; en = 1'b1;
        words = 0;
        repeat (100) begin
            @(negedge clk);
            if (rnd_valid) words++;
        end
`ifdef RNG_HEALTH_EN
        // Captures at cycles 8/24/40/56: the 4th trips the test, so only
        // passes 1-3 deliver words.
        total++; if (words !== 3) begin bad++; $display("FAIL health_words: got %0d want 3", words); end
        total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_trip: got %b want 1", health_fail); end
`else
        total++; if (words !== 6) begin bad++; $display("FAIL health_words: got %0d want 6", words); end
        total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_tied: got %b want 0", health_fail); end
`endif
        rst_n = 1'b0;
        #1;
        total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_reset: got %b want 0", health_fail); end
    endtask

    initial begin
        test_reset();
        test_hold_window();
        test_pattern(16'h55AA, 8'hF0);
        test_pattern(16'h5555, 8'hFF);
        test_all_discard();
        test_back_to_back();
        test_health();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
